// File: rtl/cpu_ctrl_pkg.sv
// Shared control types for the PC branch controller.
// Instruction classes and sequencer states.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_SEQ  = 3'd0,
    OP_JMP  = 3'd1,
    OP_JZ   = 3'd2,
    OP_JNZ  = 3'd3,
    OP_CALL = 3'd4,
    OP_RET  = 3'd5,
    OP_HALT = 3'd6,
    OP_ILL  = 3'd7
  } op_class_t;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_FAULT  = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/return_stack.sv
// LIFO of return addresses for CALL/RET.
// Top-of-stack is read combinationally so RET can jump in the same cycle.
module return_stack #(
  parameter int A     = 5,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [A-1:0]             push_data,
  output logic [A-1:0]             top,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   depth
);

  localparam int DW = $clog2(DEPTH) + 1;
  localparam int IW = $clog2(DEPTH);

  logic [A-1:0]  mem_q [DEPTH];
  logic [DW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] wr_idx, top_idx;
  logic          do_push, do_pop;

  assign full    = (ptr_q == DW'(DEPTH));
  assign empty   = (ptr_q == '0);
  assign depth   = ptr_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign wr_idx  = ptr_q[IW-1:0];
  assign top_idx = IW'(ptr_q - DW'(1));
  assign top     = mem_q[top_idx];

  always_comb begin
    ptr_d = ptr_q;
    if (do_push)
      ptr_d = ptr_q + DW'(1);
    else if (do_pop)
      ptr_d = ptr_q - DW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst)
      ptr_q <= '0;
    else
      ptr_q <= ptr_d;
  end

  always_ff @(posedge clk) begin
    if (!rst && do_push)
      mem_q[wr_idx] <= push_data;
  end

endmodule

// File: rtl/pc_branch_controller.sv
// PC jump sequencer: jumps, halt/resume, fault trap, optional call stack.
// Define PC_BRANCH_CTRL_CALL_STACK_EN to enable CALL/RET.
module pc_branch_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int BITS_FOR_INSTRUCTIONS = 5,
  parameter int STACK_DEPTH           = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [BITS_FOR_INSTRUCTIONS-1:0] instruction_address,
  input  logic [2:0]                       op_class,
  input  logic [BITS_FOR_INSTRUCTIONS-1:0] op_target,
  input  logic                             zero_flag,
  input  logic                             resume,
  output logic                             jump_enable,
  output logic [BITS_FOR_INSTRUCTIONS-1:0] jump_value,
  output logic                             halted,
  output logic                             fault,
  output logic [$clog2(STACK_DEPTH):0]     stack_depth
);

  localparam int A = BITS_FOR_INSTRUCTIONS;

  ctrl_state_t state_q, state_d;
  logic [A-1:0] halt_addr_q, halt_addr_d;
  op_class_t    op;

  logic         run_je, run_trap, run_halt;
  logic [A-1:0] run_jv;
  logic         push, pop, stk_push, stk_pop;
  logic         stk_full, stk_empty;
  logic [A-1:0] stk_top;

  assign op       = op_class_t'(op_class);
  assign stk_push = push && (state_q == ST_RUN);
  assign stk_pop  = pop && (state_q == ST_RUN);

`ifdef PC_BRANCH_CTRL_CALL_STACK_EN
  return_stack #(
    .A     (A),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (stk_push),
    .pop       (stk_pop),
    .push_data (instruction_address + A'(1)),
    .top       (stk_top),
    .full      (stk_full),
    .empty     (stk_empty),
    .depth     (stack_depth)
  );
`else
  // Full and empty at once makes both CALL and RET trap.
  logic unused_stk;
  assign unused_stk  = stk_push ^ stk_pop;
  assign stk_top     = '0;
  assign stk_full    = 1'b1;
  assign stk_empty   = 1'b1;
  assign stack_depth = '0;
`endif

  always_comb begin
    run_je   = 1'b0;
    run_jv   = '0;
    run_trap = 1'b0;
    run_halt = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;
    unique case (op)
      OP_SEQ: ;
      OP_JMP: begin
        run_je = 1'b1;
        run_jv = op_target;
      end
      OP_JZ: if (zero_flag) begin
        run_je = 1'b1;
        run_jv = op_target;
      end
      OP_JNZ: if (!zero_flag) begin
        run_je = 1'b1;
        run_jv = op_target;
      end
      OP_CALL: if (stk_full) begin
        run_trap = 1'b1;
      end else begin
        push   = 1'b1;
        run_je = 1'b1;
        run_jv = op_target;
      end
      OP_RET: if (stk_empty) begin
        run_trap = 1'b1;
      end else begin
        pop    = 1'b1;
        run_je = 1'b1;
        run_jv = stk_top;
      end
      OP_HALT: run_halt = 1'b1;
      default: run_trap = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      halt_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      halt_addr_q <= halt_addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    halt_addr_d = halt_addr_q;
    unique case (state_q)
      ST_RUN: begin
        if (run_trap) begin
          state_d     = ST_FAULT;
          halt_addr_d = instruction_address;
        end else if (run_halt) begin
          state_d     = ST_HALTED;
          halt_addr_d = instruction_address;
        end
      end
      ST_HALTED: if (resume) state_d = ST_RUN;
      ST_FAULT: ;
      default: state_d = ST_RUN;
    endcase
  end

  assign halted = (state_q == ST_HALTED);
  assign fault  = (state_q == ST_FAULT);

  always_comb begin
    jump_enable = 1'b0;
    jump_value  = '0;
    if (!rst) begin
      unique case (state_q)
        ST_RUN: begin
          // Halting or trapping instructions self-loop.
          if (run_trap || run_halt) begin
            jump_enable = 1'b1;
            jump_value  = instruction_address;
          end else begin
            jump_enable = run_je;
            jump_value  = run_jv;
          end
        end
        ST_HALTED: begin
          jump_enable = 1'b1;
          jump_value  = resume ? halt_addr_q + A'(1) : halt_addr_q;
        end
        ST_FAULT: begin
          jump_enable = 1'b1;
          jump_value  = halt_addr_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_branch_controller.sv
// Scoreboard bench for pc_branch_controller.
// Expectations are queued per cycle; a negedge monitor pops and compares.
module tb_pc_branch_controller;
  import cpu_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] instruction_address = '0;
  logic [2:0] op_class = '0;
  logic [4:0] op_target = '0;
  logic       zero_flag = 1'b0;
  logic       resume = 1'b0;
  logic       jump_enable;
  logic [4:0] jump_value;
  logic       halted;
  logic       fault;
  logic [2:0] stack_depth;

  typedef struct {
    string      name;
    logic       je;
    logic [4:0] jv;
    logic       h;
    logic       f;
    logic [2:0] d;
  } exp_t;

  exp_t q[$];
  int   passed = 0;
  int   total  = 0;

  pc_branch_controller #(
    .BITS_FOR_INSTRUCTIONS (5),
    .STACK_DEPTH           (4)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .instruction_address (instruction_address),
    .op_class            (op_class),
    .op_target           (op_target),
    .zero_flag           (zero_flag),
    .resume              (resume),
    .jump_enable         (jump_enable),
    .jump_value          (jump_value),
    .halted              (halted),
    .fault               (fault),
    .stack_depth         (stack_depth)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic ok;
      e  = q.pop_front();
      ok = (jump_enable === e.je) && (halted === e.h) &&
           (fault === e.f) && (stack_depth === e.d) &&
           (!e.je || (jump_value === e.jv));
      total++;
      if (ok)
        passed++;
      else
        $display("FAIL %s: got je=%0d jv=%0d h=%0d f=%0d d=%0d want je=%0d jv=%0d h=%0d f=%0d d=%0d",
                 e.name, jump_enable, jump_value, halted, fault,
                 stack_depth, e.je, e.jv, e.h, e.f, e.d);
    end
  end

  task automatic step(
    input string      nm,
    input logic [2:0] c,
    input logic [4:0] a,
    input logic [4:0] t,
    input logic       z,
    input logic       rs,
    input logic       r,
    input logic       je,
    input logic [4:0] jv,
    input logic       h,
    input logic       f,
    input logic [2:0] d
  );
    exp_t e;
    @(posedge clk);
    #1;
    op_class            = c;
    instruction_address = a;
    op_target           = t;
    zero_flag           = z;
    resume              = rs;
    rst                 = r;
    e.name = nm;
    e.je   = je;
    e.jv   = jv;
    e.h    = h;
    e.f    = f;
    e.d    = d;
    q.push_back(e);
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    //   name        class    addr tgt z  res rst  je jv  h  f  d
    step("rst_force", OP_JMP,  0,  5, 0, 0, 1,  0, 0,  0, 0, 0);
    step("seq0",      OP_SEQ,  0,  0, 0, 0, 0,  0, 0,  0, 0, 0);
    step("seq1",      OP_SEQ,  1,  0, 0, 0, 0,  0, 0,  0, 0, 0);
    step("seq2",      OP_SEQ,  2,  0, 0, 0, 0,  0, 0,  0, 0, 0);
    step("seq3",      OP_SEQ,  3,  0, 0, 0, 0,  0, 0,  0, 0, 0);
    step("jz_taken",  OP_JZ,   2,  9, 1, 0, 0,  1, 9,  0, 0, 0);
    step("jz_not",    OP_JZ,   2,  9, 0, 0, 0,  0, 0,  0, 0, 0);
    step("jnz_taken", OP_JNZ,  2,  9, 0, 0, 0,  1, 9,  0, 0, 0);
    step("jnz_not",   OP_JNZ,  2,  9, 1, 0, 0,  0, 0,  0, 0, 0);
    step("jmp",       OP_JMP,  3, 17, 0, 0, 0,  1, 17, 0, 0, 0);
    step("halt7",     OP_HALT, 7,  0, 0, 0, 0,  1, 7,  0, 0, 0);
    step("halted_a",  OP_JMP,  7,  3, 0, 0, 0,  1, 7,  1, 0, 0);
    step("halted_b",  OP_CALL, 7,  3, 0, 0, 0,  1, 7,  1, 0, 0);
    step("resume8",   OP_SEQ,  7,  0, 0, 1, 0,  1, 8,  1, 0, 0);
    step("run_res",   OP_SEQ,  8,  0, 0, 1, 0,  0, 0,  0, 0, 0);
    step("halt31",    OP_HALT, 31, 0, 0, 0, 0,  1, 31, 0, 0, 0);
    step("resume0",   OP_SEQ,  31, 0, 0, 1, 0,  1, 0,  1, 0, 0);
    step("after_res", OP_SEQ,  0,  0, 0, 0, 0,  0, 0,  0, 0, 0);
`ifdef PC_BRANCH_CTRL_CALL_STACK_EN
    step("call4",     OP_CALL, 4,  20, 0, 0, 0, 1, 20, 0, 0, 0);
    step("call21",    OP_CALL, 21, 20, 0, 0, 0, 1, 20, 0, 0, 1);
    step("ret22",     OP_RET,  20, 0,  0, 0, 0, 1, 22, 0, 0, 2);
    step("ret5",      OP_RET,  22, 0,  0, 0, 0, 1, 5,  0, 0, 1);
    step("depth0",    OP_SEQ,  5,  0,  0, 0, 0, 0, 0,  0, 0, 0);
    step("fill1",     OP_CALL, 0,  1,  0, 0, 0, 1, 1,  0, 0, 0);
    step("fill2",     OP_CALL, 1,  2,  0, 0, 0, 1, 2,  0, 0, 1);
    step("fill3",     OP_CALL, 2,  3,  0, 0, 0, 1, 3,  0, 0, 2);
    step("fill4",     OP_CALL, 3,  4,  0, 0, 0, 1, 4,  0, 0, 3);
    step("overflow",  OP_CALL, 4,  10, 0, 0, 0, 1, 4,  0, 0, 4);
    step("flt_res",   OP_SEQ,  9,  0,  0, 1, 0, 1, 4,  0, 1, 4);
    step("flt_ret",   OP_RET,  9,  0,  0, 0, 0, 1, 4,  0, 1, 4);
    step("flt_rst",   OP_SEQ,  0,  0,  0, 0, 1, 0, 0,  0, 1, 4);
    step("flt_clr",   OP_SEQ,  0,  0,  0, 0, 0, 0, 0,  0, 0, 0);
    step("underflow", OP_RET,  6,  0,  0, 0, 0, 1, 6,  0, 0, 0);
    step("uf_fault",  OP_SEQ,  7,  0,  0, 1, 0, 1, 6,  0, 1, 0);
    step("uf_rst",    OP_SEQ,  0,  0,  0, 0, 1, 0, 0,  0, 1, 0);
    step("uf_clr",    OP_SEQ,  0,  0,  0, 0, 0, 0, 0,  0, 0, 0);
    step("hc_call1",  OP_CALL, 0,  1,  0, 0, 0, 1, 1,  0, 0, 0);
    step("hc_call2",  OP_CALL, 1,  2,  0, 0, 0, 1, 2,  0, 0, 1);
    step("hc_halt",   OP_HALT, 2,  0,  0, 0, 0, 1, 2,  0, 0, 2);
    step("hc_held",   OP_SEQ,  2,  0,  0, 0, 0, 1, 2,  1, 0, 2);
    step("hc_rst",    OP_SEQ,  2,  0,  0, 0, 1, 0, 0,  1, 0, 2);
    step("hc_clr",    OP_JMP,  0,  6,  0, 0, 0, 1, 6,  0, 0, 0);
`else
    step("call_ill",  OP_CALL, 4,  20, 0, 0, 0, 1, 4,  0, 0, 0);
    step("ci_fault",  OP_SEQ,  5,  0,  0, 1, 0, 1, 4,  0, 1, 0);
    step("ci_rst",    OP_SEQ,  0,  0,  0, 0, 1, 0, 0,  0, 1, 0);
    step("ci_clr",    OP_SEQ,  0,  0,  0, 0, 0, 0, 0,  0, 0, 0);
    step("ret_ill",   OP_RET,  5,  0,  0, 0, 0, 1, 5,  0, 0, 0);
    step("ri_fault",  OP_JMP,  6,  9,  0, 0, 0, 1, 5,  0, 1, 0);
    step("ri_rst",    OP_SEQ,  0,  0,  0, 0, 1, 0, 0,  0, 1, 0);
    step("ri_clr",    OP_SEQ,  0,  0,  0, 0, 0, 0, 0,  0, 0, 0);
`endif
    step("illegal",   OP_ILL,  3,  12, 0, 0, 0, 1, 3,  0, 0, 0);
    step("ill_fault", OP_JMP,  8,  12, 0, 1, 0, 1, 3,  0, 1, 0);
    step("ill_rst",   OP_SEQ,  0,  0,  0, 0, 1, 0, 0,  0, 1, 0);
    step("ill_clr",   OP_SEQ,  1,  0,  0, 0, 0, 0, 0,  0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    #1;
    total++;
    if (q.size() == 0)
      passed++;
    else
      $display("FAIL drain: got %0d pending want 0", q.size());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
